// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store to word-memory bridge (req/we/funct3/addr/wdata in; busy/done/err/rdata out; mem_A/mem_WD/mem_WE out, mem_RD in)
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;
  state_t      state_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, merged_q;
  logic        illegal, misaligned, bad, mem_active;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_d, lane_m, lane_d, merge_d;
  always_comb begin
    illegal    = we ? (funct3 > 3'b010) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    bad        = illegal || misaligned || addr >= MEM_BYTES;
    mem_active = state_q == LOAD || state_q == RMW_READ || state_q == WRITE;
    mem_A      = mem_active ? {addr_q[31:2], 2'b00} : 32'd0;
    byte_sel   = mem_RD[{addr_q[1:0], 3'b000} +: 8];
    half_sel   = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    load_d     = f3_q[1] ? mem_RD :
                 f3_q[0] ? {{16{!f3_q[2] && half_sel[15]}}, half_sel} :
                           {{24{!f3_q[2] && byte_sel[7]}}, byte_sel};
    lane_m     = f3_q[0] ? (32'h0000FFFF << {addr_q[1], 4'b0000}) : (32'h000000FF << {addr_q[1:0], 3'b000});
    lane_d     = f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
    merge_d    = (mem_RD & ~lane_m) | (lane_d & lane_m);
    mem_WD     = state_q == WRITE ? (f3_q[1] ? wdata_q : merged_q) : 32'd0;
    mem_WE     = state_q == WRITE && !rst;
    busy       = state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      f3_q     <= 3'b000;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      merged_q <= 32'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (req) begin
          f3_q    <= funct3;
          addr_q  <= addr;
          wdata_q <= wdata;
          if (bad) begin
            state_q <= RESP;
            done    <= 1'b1;
            err     <= 1'b1;
            rdata   <= 32'd0;
          end else begin
            state_q <= !we ? LOAD : funct3[1] ? WRITE : RMW_READ;
          end
        end
        LOAD: begin
          rdata   <= load_d;
          err     <= 1'b0;
          done    <= 1'b1;
          state_q <= RESP;
        end
        RMW_READ: begin
          merged_q <= merge_d;
          state_q  <= WRITE;
        end
        WRITE: begin
          err     <= 1'b0;
          done    <= 1'b1;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU datapath and the byte-addressed, word-wide data memory (Data_Mem-style: word address, 32-bit WD/RD, full-word WE, asynchronous read).
- Turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Extracts and extends the selected byte or halfword on loads.
- Performs read-modify-write for sub-word stores, and flags misaligned, illegal or out-of-range accesses with a req/busy/done handshake.

Parameters:
- MEM_BYTES, 65536, size of the data memory in bytes; any access with byte address >= MEM_BYTES is an error.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- req  input  1  request strobe from the CPU; sampled only in IDLE
- we  input  1  1 = store, 0 = load
- funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  byte address
- wdata  input  32  store data; the low byte or halfword is used for SB/SH
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse in RESP
- err  output  1  valid with done; 1 = access rejected
- rdata  output  32  load result, valid with done
- mem_A  output  32  word-aligned address to memory
- mem_WD  output  32  write data to memory
- mem_WE  output  1  memory write enable
- mem_RD  input  32  memory read data (combinational from mem_A)

Behaviour:
- Reset: rst=1 at a rising edge forces state to IDLE. Registered outputs clear (done=0, err=0, rdata=0) and captured request registers clear.
  - mem_WE is gated by !rst combinationally, so no write commits on a reset edge, even mid-RMW_WRITE.
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE: on req=1, capture we, funct3, addr and wdata, then classify:
  - Illegal: load funct3 in {011, 110, 111}, or store funct3 > 010.
  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
  - Out of range: addr >= MEM_BYTES.
- Transitions out of IDLE:
  - Any error -> RESP with err=1, rdata=0, no memory write.
  - Load -> LOAD.
  - SW -> WRITE.
  - SB/SH -> RMW_READ.
- LOAD: mem_A={addr_q[31:2],2'b00}. Select byte addr_q[1:0] or halfword addr_q[1]. Sign-extend for B/H, zero-extend for BU/HU, pass through for W. Register into rdata -> RESP.
- RMW_READ: mem_A as in LOAD. Capture mem_RD, replace the addressed byte/halfword lane with wdata[7:0] or wdata[15:0], store the merged word -> WRITE.
- WRITE: mem_A as in LOAD; mem_WE=1 for exactly this one cycle.
  - mem_WD = wdata_q for SW, merged word for SB/SH.
  - -> RESP.
- RESP: done=1 with err and rdata stable -> IDLE. rdata holds its value until the next load completes; it is not cleared on stores.
- Latency (accept edge to done): load 2 cycles, SW 2, SB/SH 3, error 1.
- req while busy=1 is ignored and not queued; the CPU must hold or re-issue it after done.
- Outside LOAD/RMW_READ/WRITE: mem_A=0, mem_WD=0, mem_WE=0.
- Extraction and merge are purely combinational on captured registers. Inputs changing after acceptance have no effect.

Test Plan:
- Preload word 0x10 = 0x80FF7F01:
  - LB 0x13 -> rdata 0xFFFFFF80.
  - LBU 0x13 -> 0x00000080.
  - LH 0x12 -> 0xFFFF80FF.
  - LHU 0x10 -> 0x00007F01.
  - Each: done 2 cycles after accept, err=0, mem_WE never high.
- SB addr 0x11, wdata 0x123456AA -> mem_WE high exactly 1 cycle with mem_A=0x10, mem_WD=0x80FFAA01; done 3 cycles after accept; a following LW 0x10 returns 0x80FFAA01.
- SW addr 0x20, wdata 0xDEADBEEF -> one WE cycle with mem_WD 0xDEADBEEF, done at 2 cycles; SH 0x22, wdata 0x0000CAFE then LW 0x20 -> 0xCAFEBEEF.
- LW 0x12, SH 0x21, funct3=011 load, and LW 0x10000 (MEM_BYTES=65536) -> each done 1 cycle after accept with err=1, rdata=0, mem_WE never asserted.
- req pulsed while busy during an SB -> ignored: one done only, memory changes once.
- rst=1 during the WRITE cycle of SH 0x30 -> word at 0x30 unchanged, state IDLE, busy=0, done=0 next cycle; a new LW then completes normally.
